// File: rtl/tl_ul_rr_arbiter.sv
// Two-master to one-slave TileLink-UL arbiter: round-robin A-channel grant with
// held offers, source tagging by master index, D routing, per-master outstanding limits.
module tl_ul_rr_arbiter #(
  parameter int SRC_W   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             m0_a_valid,
  output logic             m0_a_ready,
  input  logic [2:0]       m0_a_opcode,
  input  logic [2:0]       m0_a_param,
  input  logic [1:0]       m0_a_size,
  input  logic [SRC_W-1:0] m0_a_source,
  input  logic [31:0]      m0_a_address,
  input  logic [3:0]       m0_a_mask,
  input  logic [31:0]      m0_a_data,
  output logic             m0_d_valid,
  input  logic             m0_d_ready,
  output logic [2:0]       m0_d_opcode,
  output logic [1:0]       m0_d_size,
  output logic [SRC_W-1:0] m0_d_source,
  output logic [31:0]      m0_d_data,
  output logic             m0_d_denied,

  input  logic             m1_a_valid,
  output logic             m1_a_ready,
  input  logic [2:0]       m1_a_opcode,
  input  logic [2:0]       m1_a_param,
  input  logic [1:0]       m1_a_size,
  input  logic [SRC_W-1:0] m1_a_source,
  input  logic [31:0]      m1_a_address,
  input  logic [3:0]       m1_a_mask,
  input  logic [31:0]      m1_a_data,
  output logic             m1_d_valid,
  input  logic             m1_d_ready,
  output logic [2:0]       m1_d_opcode,
  output logic [1:0]       m1_d_size,
  output logic [SRC_W-1:0] m1_d_source,
  output logic [31:0]      m1_d_data,
  output logic             m1_d_denied,

  output logic             s_a_valid,
  input  logic             s_a_ready,
  output logic [2:0]       s_a_opcode,
  output logic [2:0]       s_a_param,
  output logic [1:0]       s_a_size,
  output logic [SRC_W:0]   s_a_source,
  output logic [31:0]      s_a_address,
  output logic [3:0]       s_a_mask,
  output logic [31:0]      s_a_data,
  input  logic             s_d_valid,
  output logic             s_d_ready,
  input  logic [2:0]       s_d_opcode,
  input  logic [1:0]       s_d_size,
  input  logic [SRC_W:0]   s_d_source,
  input  logic [31:0]      s_d_data,
  input  logic             s_d_denied
);

  localparam logic [3:0] LP_MAX_OUT = 4'(MAX_OUT);

  logic       r_rr_last;
  logic       r_lock;
  logic       r_lock_idx;
  logic [3:0] r_cnt0;
  logic [3:0] r_cnt1;

  logic w_req0;
  logic w_req1;
  logic w_grant;
  logic w_a_valid;
  logic w_a_fire;
  logic w_d_idx;
  logic w_d_ready;
  logic w_d_fire;
  logic w_inc0;
  logic w_inc1;
  logic w_dec0;
  logic w_dec1;

  assign w_req0 = m0_a_valid && (r_cnt0 < LP_MAX_OUT);
  assign w_req1 = m1_a_valid && (r_cnt1 < LP_MAX_OUT);

  // A held offer keeps its master; otherwise the master not served last wins a tie.
  always_comb begin
    w_grant = 1'b0;
    if (r_lock) begin
      w_grant = r_lock_idx;
    end else if (w_req0 && w_req1) begin
      w_grant = ~r_rr_last;
    end else if (w_req1) begin
      w_grant = 1'b1;
    end
  end

  assign w_a_valid  = !reset && (r_lock || w_req0 || w_req1);
  assign w_a_fire   = w_a_valid && s_a_ready;
  assign s_a_valid  = w_a_valid;
  assign m0_a_ready = w_a_valid && !w_grant && s_a_ready;
  assign m1_a_ready = w_a_valid &&  w_grant && s_a_ready;

  always_comb begin
    if (w_grant) begin
      s_a_opcode  = m1_a_opcode;
      s_a_param   = m1_a_param;
      s_a_size    = m1_a_size;
      s_a_source  = {1'b1, m1_a_source};
      s_a_address = m1_a_address;
      s_a_mask    = m1_a_mask;
      s_a_data    = m1_a_data;
    end else begin
      s_a_opcode  = m0_a_opcode;
      s_a_param   = m0_a_param;
      s_a_size    = m0_a_size;
      s_a_source  = {1'b0, m0_a_source};
      s_a_address = m0_a_address;
      s_a_mask    = m0_a_mask;
      s_a_data    = m0_a_data;
    end
  end

  // The top source bit carries the master index the request was granted to.
  assign w_d_idx    = s_d_source[SRC_W];
  assign m0_d_valid = !reset && s_d_valid && !w_d_idx;
  assign m1_d_valid = !reset && s_d_valid &&  w_d_idx;
  assign w_d_ready  = !reset && (w_d_idx ? m1_d_ready : m0_d_ready);
  assign s_d_ready  = w_d_ready;
  assign w_d_fire   = s_d_valid && w_d_ready;

  assign m0_d_opcode = s_d_opcode;
  assign m0_d_size   = s_d_size;
  assign m0_d_source = s_d_source[SRC_W-1:0];
  assign m0_d_data   = s_d_data;
  assign m0_d_denied = s_d_denied;
  assign m1_d_opcode = s_d_opcode;
  assign m1_d_size   = s_d_size;
  assign m1_d_source = s_d_source[SRC_W-1:0];
  assign m1_d_data   = s_d_data;
  assign m1_d_denied = s_d_denied;

  assign w_inc0 = w_a_fire && !w_grant;
  assign w_inc1 = w_a_fire &&  w_grant;
  assign w_dec0 = w_d_fire && !w_d_idx && (r_cnt0 != 4'd0);
  assign w_dec1 = w_d_fire &&  w_d_idx && (r_cnt1 != 4'd0);

  // Lock is taken by a stalled offer; counters saturate at zero on stray responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_last  <= 1'b1;
      r_lock     <= 1'b0;
      r_lock_idx <= 1'b0;
      r_cnt0     <= 4'd0;
      r_cnt1     <= 4'd0;
    end else begin
      if (w_a_fire) begin
        r_lock    <= 1'b0;
        r_rr_last <= w_grant;
      end else if (w_a_valid) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant;
      end
      case ({w_inc0, w_dec0})
        2'b10:   r_cnt0 <= r_cnt0 + 4'd1;
        2'b01:   r_cnt0 <= r_cnt0 - 4'd1;
        default: r_cnt0 <= r_cnt0;
      endcase
      case ({w_inc1, w_dec1})
        2'b10:   r_cnt1 <= r_cnt1 + 4'd1;
        2'b01:   r_cnt1 <= r_cnt1 - 4'd1;
        default: r_cnt1 <= r_cnt1;
      endcase
    end
  end

  a_no_d_underflow0: assert property (@(posedge clock) disable iff (reset)
    !(w_d_fire && !w_d_idx && (r_cnt0 == 4'd0)));
  a_no_d_underflow1: assert property (@(posedge clock) disable iff (reset)
    !(w_d_fire && w_d_idx && (r_cnt1 == 4'd0)));

endmodule

// File: tb/tb_tl_ul_rr_arbiter.sv
// Bench for tl_ul_rr_arbiter: directed scenarios plus a randomized run, all checked
// against a transaction-level model of grants, outstanding requests and responses.
module tb_tl_ul_rr_arbiter;

  localparam int SRC_W   = 8;
  localparam int MAX_OUT = 4;

  logic clock;
  logic reset;

  logic m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
  logic [2:0] m0_a_opcode, m0_a_param, m1_a_opcode, m1_a_param;
  logic [1:0] m0_a_size, m1_a_size;
  logic [7:0] m0_a_source, m1_a_source;
  logic [31:0] m0_a_address, m0_a_data, m1_a_address, m1_a_data;
  logic [3:0] m0_a_mask, m1_a_mask;
  logic m0_d_valid, m0_d_ready, m0_d_denied, m1_d_valid, m1_d_ready, m1_d_denied;
  logic [2:0] m0_d_opcode, m1_d_opcode;
  logic [1:0] m0_d_size, m1_d_size;
  logic [7:0] m0_d_source, m1_d_source;
  logic [31:0] m0_d_data, m1_d_data;
  logic s_a_valid, s_a_ready, s_d_valid, s_d_ready, s_d_denied;
  logic [2:0] s_a_opcode, s_a_param, s_d_opcode;
  logic [1:0] s_a_size, s_d_size;
  logic [8:0] s_a_source, s_d_source;
  logic [31:0] s_a_address, s_a_data, s_d_data;
  logic [3:0] s_a_mask;

  int vecCount  = 0;
  int missCount = 0;

  // Model: requests accepted but not yet answered, per master count, who was served last,
  // and which master's offer is currently waiting on the slave (-1 when none).
  int mCnt[2];
  int mLast;
  int mHeld;
  logic [8:0] outQ[$];

  tl_ul_rr_arbiter #(.SRC_W(SRC_W), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .reset(reset),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
    .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
    .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
    .m0_d_size(m0_d_size), .m0_d_source(m0_d_source), .m0_d_data(m0_d_data),
    .m0_d_denied(m0_d_denied),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
    .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
    .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
    .m1_d_size(m1_d_size), .m1_d_source(m1_d_source), .m1_d_data(m1_d_data),
    .m1_d_denied(m1_d_denied),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
    .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_size(s_d_size), .s_d_source(s_d_source), .s_d_data(s_d_data),
    .s_d_denied(s_d_denied)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit masterValid(input int n);
    return (n == 0) ? (m0_a_valid === 1'b1) : (m1_a_valid === 1'b1);
  endfunction

  // A waiting offer keeps the slave; otherwise scan masters starting after the last one served.
  function automatic int expGrant();
    if (mHeld >= 0) return mHeld;
    for (int k = 1; k <= 2; k++) begin
      int c;
      c = (mLast + k) % 2;
      if (masterValid(c) && mCnt[c] < MAX_OUT) return c;
    end
    return -1;
  endfunction

  task automatic modelInit();
    mCnt[0] = 0;
    mCnt[1] = 0;
    mLast   = 1;
    mHeld   = -1;
    outQ.delete();
  endtask

  // Apply the current cycle's handshakes to the model, then advance to the next cycle.
  task automatic clockModel(output bit f0, output bit f1, output bit fd);
    int g;
    int di;
    f0 = 0; f1 = 0; fd = 0;
    if (reset === 1'b1) begin
      modelInit();
    end else begin
      g = expGrant();
      if (g >= 0) begin
        if (s_a_ready === 1'b1) begin
          mCnt[g]++;
          mLast = g;
          mHeld = -1;
          outQ.push_back((g == 1) ? {1'b1, m1_a_source} : {1'b0, m0_a_source});
          if (g == 0) f0 = 1; else f1 = 1;
        end else begin
          mHeld = g;
        end
      end
      di = s_d_source[8] ? 1 : 0;
      if (s_d_valid === 1'b1 && ((di == 1) ? m1_d_ready : m0_d_ready) === 1'b1) begin
        fd = 1;
        if (mCnt[di] > 0) mCnt[di]--;
        for (int k = 0; k < outQ.size(); k++) begin
          if (outQ[k] === s_d_source) begin
            outQ.delete(k);
            break;
          end
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    bit a, b, c;
    clockModel(a, b, c);
  endtask

  task automatic setM0(input logic v, input logic [2:0] op, input logic [7:0] src,
                       input logic [31:0] addr, input logic [31:0] data);
    m0_a_valid = v; m0_a_opcode = op; m0_a_param = 3'd0; m0_a_size = 2'd2;
    m0_a_source = src; m0_a_address = addr; m0_a_mask = 4'hF; m0_a_data = data;
  endtask

  task automatic setM1(input logic v, input logic [2:0] op, input logic [7:0] src,
                       input logic [31:0] addr, input logic [31:0] data);
    m1_a_valid = v; m1_a_opcode = op; m1_a_param = 3'd0; m1_a_size = 2'd2;
    m1_a_source = src; m1_a_address = addr; m1_a_mask = 4'hF; m1_a_data = data;
  endtask

  task automatic clearInputs();
    setM0(1'b0, 3'd0, 8'd0, 32'd0, 32'd0);
    setM1(1'b0, 3'd0, 8'd0, 32'd0, 32'd0);
    m0_d_ready = 0; m1_d_ready = 0; s_a_ready = 0;
    s_d_valid = 0; s_d_opcode = 3'd1; s_d_size = 2'd2; s_d_source = 9'd0;
    s_d_data = 32'd0; s_d_denied = 0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearInputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    setM0(1'b1, 3'd4, 8'h01, 32'h10, 32'h0);
    setM1(1'b1, 3'd4, 8'h02, 32'h20, 32'h0);
    s_a_ready = 1; s_d_valid = 1; s_d_source = 9'h001; m0_d_ready = 1; m1_d_ready = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecCount++; if (s_a_valid !== 1'b0) begin missCount++; $display("[TB] FAIL rst_s_a_valid got=%b exp=0", s_a_valid); end
      vecCount++; if (m0_a_ready !== 1'b0 || m1_a_ready !== 1'b0) begin missCount++; $display("[TB] FAIL rst_a_ready got=%b%b exp=00", m0_a_ready, m1_a_ready); end
      vecCount++; if (m0_d_valid !== 1'b0 || m1_d_valid !== 1'b0) begin missCount++; $display("[TB] FAIL rst_d_valid got=%b%b exp=00", m0_d_valid, m1_d_valid); end
      vecCount++; if (s_d_ready !== 1'b0) begin missCount++; $display("[TB] FAIL rst_s_d_ready got=%b exp=0", s_d_ready); end
      tick();
    end
    reset = 1'b0;
    clearInputs();
    #1;
    vecCount++; if (s_a_valid !== 1'b0) begin missCount++; $display("[TB] FAIL idle_s_a_valid got=%b exp=0", s_a_valid); end
    tick();
  endtask

  task automatic test_single_get();
    doReset();
    setM0(1'b1, 3'd4, 8'h12, 32'h1000_0000, 32'h0);
    s_a_ready = 1;
    #1;
    vecCount++; if (s_a_valid !== 1'b1) begin missCount++; $display("[TB] FAIL get_s_a_valid got=%b exp=1", s_a_valid); end
    vecCount++; if (s_a_source !== 9'h012) begin missCount++; $display("[TB] FAIL get_s_a_source got=%h exp=012", s_a_source); end
    vecCount++; if (s_a_address !== 32'h1000_0000 || s_a_opcode !== 3'd4) begin missCount++; $display("[TB] FAIL get_fields got=%h/%0d exp=10000000/4", s_a_address, s_a_opcode); end
    vecCount++; if (m0_a_ready !== 1'b1 || m1_a_ready !== 1'b0) begin missCount++; $display("[TB] FAIL get_a_ready got=%b%b exp=10", m0_a_ready, m1_a_ready); end
    tick();
    m0_a_valid = 0;
    s_d_valid = 1; s_d_source = 9'h012; s_d_data = 32'h0BAD_F00D; m0_d_ready = 1;
    #1;
    vecCount++; if (m0_d_valid !== 1'b1 || m0_d_source !== 8'h12 || m0_d_data !== 32'h0BAD_F00D) begin missCount++; $display("[TB] FAIL get_resp got=%b/%h/%h exp=1/12/0badf00d", m0_d_valid, m0_d_source, m0_d_data); end
    vecCount++; if (s_d_ready !== 1'b1 || m1_d_valid !== 1'b0) begin missCount++; $display("[TB] FAIL get_resp_route got=%b%b exp=10", s_d_ready, m1_d_valid); end
    tick();
    s_d_valid = 0;
  endtask

  task automatic test_alternate();
    logic [8:0] prevSrc;
    logic prevFire;
    doReset();
    setM0(1'b1, 3'd4, 8'hA0, 32'h100, 32'h0);
    setM1(1'b1, 3'd4, 8'hB1, 32'h200, 32'h0);
    s_a_ready = 1; m0_d_ready = 1; m1_d_ready = 1;
    prevFire = 0; prevSrc = 9'd0;
    for (int i = 0; i < 8; i++) begin
      s_d_valid = prevFire; s_d_source = prevSrc;
      #1;
      vecCount++; if (s_a_source[8] !== 1'(i % 2) || s_a_valid !== 1'b1) begin missCount++; $display("[TB] FAIL alt_grant i=%0d got=%b exp=%0d", i, s_a_source[8], i % 2); end
      vecCount++; if (m0_a_ready !== 1'(i % 2 == 0) || m1_a_ready !== 1'(i % 2 == 1)) begin missCount++; $display("[TB] FAIL alt_ready i=%0d got=%b%b", i, m0_a_ready, m1_a_ready); end
      prevFire = 1;
      prevSrc = (i % 2 == 0) ? 9'h0A0 : 9'h1B1;
      tick();
    end
    s_d_valid = 0;
  endtask

  task automatic test_lock();
    doReset();
    setM1(1'b1, 3'd4, 8'h33, 32'h2000_0040, 32'h0);
    s_a_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) setM0(1'b1, 3'd0, 8'h44, 32'h1000_0080, 32'h1234_5678);
      #1;
      vecCount++; if (s_a_source !== 9'h133 || s_a_address !== 32'h2000_0040 || s_a_valid !== 1'b1) begin missCount++; $display("[TB] FAIL lock_hold i=%0d got=%h/%h exp=133/20000040", i, s_a_source, s_a_address); end
      vecCount++; if (m0_a_ready !== 1'b0 || m1_a_ready !== 1'b0) begin missCount++; $display("[TB] FAIL lock_ready i=%0d got=%b%b exp=00", i, m0_a_ready, m1_a_ready); end
      tick();
    end
    s_a_ready = 1;
    #1;
    vecCount++; if (m1_a_ready !== 1'b1 || m0_a_ready !== 1'b0 || s_a_source !== 9'h133) begin missCount++; $display("[TB] FAIL lock_fire got=%b%b/%h exp=01/133", m0_a_ready, m1_a_ready, s_a_source); end
    tick();
    #1;
    vecCount++; if (s_a_source !== 9'h044 || m0_a_ready !== 1'b1 || s_a_data !== 32'h1234_5678) begin missCount++; $display("[TB] FAIL lock_next got=%h/%b exp=044/1", s_a_source, m0_a_ready); end
    tick();
  endtask

  task automatic test_outstanding();
    doReset();
    s_a_ready = 1;
    for (int i = 0; i < MAX_OUT; i++) begin
      setM0(1'b1, 3'd4, 8'(i), 32'h3000_0000 + 32'(i * 4), 32'h0);
      #1;
      vecCount++; if (m0_a_ready !== 1'b1 || s_a_source !== {1'b0, 8'(i)}) begin missCount++; $display("[TB] FAIL out_fill i=%0d got=%b/%h", i, m0_a_ready, s_a_source); end
      tick();
    end
    setM0(1'b1, 3'd4, 8'h04, 32'h3000_0010, 32'h0);
    setM1(1'b1, 3'd4, 8'h50, 32'h4000_0000, 32'h0);
    #1;
    vecCount++; if (m0_a_ready !== 1'b0 || m1_a_ready !== 1'b1 || s_a_source !== 9'h150) begin missCount++; $display("[TB] FAIL out_full got=%b%b/%h exp=01/150", m0_a_ready, m1_a_ready, s_a_source); end
    tick();
    m1_a_valid = 0;
    #1;
    vecCount++; if (s_a_valid !== 1'b0 || m0_a_ready !== 1'b0) begin missCount++; $display("[TB] FAIL out_block got=%b%b exp=00", s_a_valid, m0_a_ready); end
    tick();
    s_d_valid = 1; s_d_source = 9'h002; m0_d_ready = 1;
    #1;
    vecCount++; if (m0_d_valid !== 1'b1 || s_d_ready !== 1'b1 || m0_a_ready !== 1'b0) begin missCount++; $display("[TB] FAIL out_drain got=%b%b%b exp=110", m0_d_valid, s_d_ready, m0_a_ready); end
    tick();
    s_d_valid = 0;
    #1;
    vecCount++; if (m0_a_ready !== 1'b1 || s_a_source !== 9'h004) begin missCount++; $display("[TB] FAIL out_unblock got=%b/%h exp=1/004", m0_a_ready, s_a_source); end
    tick();
  endtask

  task automatic test_d_backpressure();
    doReset();
    setM1(1'b1, 3'd4, 8'h05, 32'h5000_0000, 32'h0);
    s_a_ready = 1;
    tick();
    m1_a_valid = 0;
    s_d_valid = 1; s_d_source = 9'h105; s_d_data = 32'hDEAD_BEEF; m1_d_ready = 0; m0_d_ready = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecCount++; if (m1_d_valid !== 1'b1 || m1_d_source !== 8'h05 || m1_d_data !== 32'hDEAD_BEEF) begin missCount++; $display("[TB] FAIL dbp_m1 i=%0d got=%b/%h/%h", i, m1_d_valid, m1_d_source, m1_d_data); end
      vecCount++; if (s_d_ready !== 1'b0 || m0_d_valid !== 1'b0) begin missCount++; $display("[TB] FAIL dbp_stall i=%0d got=%b%b exp=00", i, s_d_ready, m0_d_valid); end
      tick();
    end
    m1_d_ready = 1;
    #1;
    vecCount++; if (s_d_ready !== 1'b1 || m1_d_valid !== 1'b1 || m0_d_valid !== 1'b0) begin missCount++; $display("[TB] FAIL dbp_release got=%b%b%b exp=110", s_d_ready, m1_d_valid, m0_d_valid); end
    tick();
    s_d_valid = 0;
  endtask

  task automatic test_same_cycle();
    doReset();
    s_a_ready = 1;
    for (int i = 1; i <= 2; i++) begin
      setM0(1'b1, 3'd4, 8'(i), 32'h6000_0000, 32'h0);
      tick();
    end
    setM0(1'b1, 3'd4, 8'h03, 32'h6000_0000, 32'h0);
    s_d_valid = 1; s_d_source = 9'h001; m0_d_ready = 1;
    #1;
    vecCount++; if (m0_a_ready !== 1'b1 || s_d_ready !== 1'b1) begin missCount++; $display("[TB] FAIL same_both got=%b%b exp=11", m0_a_ready, s_d_ready); end
    tick();
    s_d_valid = 0;
    for (int i = 0; i < 3; i++) begin
      setM0(1'b1, 3'd4, 8'(4 + i), 32'h6000_0000, 32'h0);
      #1;
      vecCount++; if (m0_a_ready !== 1'(i < 2)) begin missCount++; $display("[TB] FAIL same_count i=%0d got=%b exp=%0d", i, m0_a_ready, (i < 2)); end
      tick();
    end
  endtask

  task automatic test_reset_mid_lock();
    doReset();
    setM0(1'b1, 3'd4, 8'h07, 32'h7000_0000, 32'h0);
    s_a_ready = 0;
    tick();
    reset = 1; s_d_valid = 1; s_d_source = 9'h007; m0_d_ready = 1; s_a_ready = 1;
    #1;
    vecCount++; if (s_a_valid !== 1'b0 || m0_a_ready !== 1'b0 || m1_a_ready !== 1'b0) begin missCount++; $display("[TB] FAIL rml_a got=%b%b%b exp=000", s_a_valid, m0_a_ready, m1_a_ready); end
    vecCount++; if (m0_d_valid !== 1'b0 || m1_d_valid !== 1'b0 || s_d_ready !== 1'b0) begin missCount++; $display("[TB] FAIL rml_d got=%b%b%b exp=000", m0_d_valid, m1_d_valid, s_d_ready); end
    tick();
    reset = 0; s_d_valid = 0; m0_a_valid = 0;
    setM1(1'b1, 3'd4, 8'h08, 32'h8000_0000, 32'h0);
    #1;
    vecCount++; if (s_a_source !== 9'h108 || m1_a_ready !== 1'b1) begin missCount++; $display("[TB] FAIL rml_unlock got=%h/%b exp=108/1", s_a_source, m1_a_ready); end
    tick();
  endtask

  task automatic test_random();
    bit f0, f1, fd;
    int g;
    logic [8:0] expSrc;
    logic [31:0] expAddr;
    doReset();
    f0 = 0; f1 = 0; fd = 0;
    for (int c = 0; c < 400; c++) begin
      if (!m0_a_valid || f0) setM0($urandom_range(0, 99) < 60, 3'($urandom_range(0, 4)), 8'($urandom), $urandom, $urandom);
      if (!m1_a_valid || f1) setM1($urandom_range(0, 99) < 60, 3'($urandom_range(0, 4)), 8'($urandom), $urandom, $urandom);
      s_a_ready = ($urandom_range(0, 99) < 70);
      if (!s_d_valid || fd) begin
        if (outQ.size() > 0 && $urandom_range(0, 99) < 50) begin
          s_d_valid = 1;
          s_d_source = outQ[$urandom_range(0, outQ.size() - 1)];
          s_d_data = $urandom;
        end else begin
          s_d_valid = 0;
        end
      end
      m0_d_ready = ($urandom_range(0, 99) < 70);
      m1_d_ready = ($urandom_range(0, 99) < 70);
      #1;
      g = expGrant();
      expSrc  = (g == 1) ? {1'b1, m1_a_source} : {1'b0, m0_a_source};
      expAddr = (g == 1) ? m1_a_address : m0_a_address;
      vecCount++; if (s_a_valid !== 1'(g >= 0)) begin missCount++; $display("[TB] FAIL rnd_s_a_valid c=%0d got=%b exp=%0d", c, s_a_valid, (g >= 0)); end
      vecCount++; if (m0_a_ready !== 1'(g == 0 && s_a_ready) || m1_a_ready !== 1'(g == 1 && s_a_ready)) begin missCount++; $display("[TB] FAIL rnd_a_ready c=%0d got=%b%b grant=%0d", c, m0_a_ready, m1_a_ready, g); end
      if (g >= 0) begin
        vecCount++; if (s_a_source !== expSrc || s_a_address !== expAddr) begin missCount++; $display("[TB] FAIL rnd_s_a_fields c=%0d got=%h/%h exp=%h/%h", c, s_a_source, s_a_address, expSrc, expAddr); end
      end
      vecCount++; if (m0_d_valid !== 1'(s_d_valid && !s_d_source[8]) || m1_d_valid !== 1'(s_d_valid && s_d_source[8])) begin missCount++; $display("[TB] FAIL rnd_d_valid c=%0d got=%b%b", c, m0_d_valid, m1_d_valid); end
      vecCount++; if (s_d_ready !== (s_d_source[8] ? m1_d_ready : m0_d_ready) || m1_d_source !== s_d_source[7:0]) begin missCount++; $display("[TB] FAIL rnd_d_route c=%0d got=%b/%h", c, s_d_ready, m1_d_source); end
      clockModel(f0, f1, fd);
    end
    clearInputs();
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();
    modelInit();
    @(posedge clock);
    #1;
    test_reset();
    test_single_get();
    test_alternate();
    test_lock();
    test_outstanding();
    test_d_backpressure();
    test_same_cycle();
    test_reset_mid_lock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
